// File: rtl/oj_judge_monitor.sv
// oj_judge_monitor: judging end of the OJ bench.
// Compares the sampled reference and user outputs over a fixed window after
// a start pulse, counts mismatches, records the first failing sample index
// and issues a pass/fail verdict.
// Optional feature: define OJ_JUDGE_HIST_EN to add the hist_ref/hist_dut
// sample history outputs.
module oj_judge_monitor #(
  parameter int WIN_LEN = 8,
  parameter int SKIP    = 2,
  parameter int CNT_W   = 8,
  parameter int CYC_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             ref_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef OJ_JUDGE_HIST_EN
  ,
  output logic [7:0]       hist_ref,
  output logic [7:0]       hist_dut
`endif
);

  // The sample index always needs enough bits to reach WIN_LEN-1, even when
  // the externally visible cycle_cnt is narrower.
  localparam int IDX_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIN_LEN - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  run_idx;
  logic [SKIP_W-1:0] skip_cnt;
  logic              diff;
  logic              start_run;
  logic              sample;
  logic              last_sample;

  assign diff      = ref_out ^ dut_out;
  assign cycle_cnt = CNT_W'(run_idx);

  // State register; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the status outputs derived from the current state.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    mismatch    = 1'b0;
    start_run   = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_run  = 1'b1;
          next_state = (SKIP > 0) ? ST_SKIP : ST_RUN;
        end
      end
      ST_SKIP: begin
        busy = 1'b1;
        if (skip_cnt == SKIP_LAST) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        sample   = 1'b1;
        mismatch = diff;
        if (run_idx == IDX_LAST) begin
          last_sample = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          start_run  = 1'b1;
          next_state = (SKIP > 0) ? ST_SKIP : ST_RUN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Settle counter: ticks through the ignored cycles that follow a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skip_cnt <= '0;
    end else if (start_run) begin
      skip_cnt <= '0;
    end else if (state == ST_SKIP && skip_cnt != SKIP_LAST) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end

  // Judging datapath: sample index, saturating mismatch count, first error
  // position and the verdict latched together with the final sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_idx       <= '0;
      mismatch_cnt  <= '0;
      first_err_cyc <= '1;
      pass          <= 1'b0;
    end else if (start_run) begin
      run_idx       <= '0;
      mismatch_cnt  <= '0;
      first_err_cyc <= '1;
      pass          <= 1'b0;
    end else if (sample) begin
      if (diff && mismatch_cnt != '1) begin
        mismatch_cnt <= mismatch_cnt + 1'b1;
      end
      if (diff && first_err_cyc == '1) begin
        first_err_cyc <= CYC_W'(run_idx);
      end
      if (last_sample) begin
        pass <= (mismatch_cnt == '0) && !diff;
      end else begin
        run_idx <= run_idx + 1'b1;
      end
    end
  end

`ifdef OJ_JUDGE_HIST_EN
  // Sample history: shifts while no mismatch has been seen, so the first
  // mismatching sample ends up frozen in bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_ref <= '0;
      hist_dut <= '0;
    end else if (start_run) begin
      hist_ref <= '0;
      hist_dut <= '0;
    end else if (sample && first_err_cyc == '1) begin
      hist_ref <= {hist_ref[6:0], ref_out};
      hist_dut <= {hist_dut[6:0], dut_out};
    end
  end
`endif

endmodule

// File: tb/tb_oj_judge_monitor.sv
// Testbench for oj_judge_monitor: randomized and directed judging runs with a
// scoreboard. Two instances share the stimulus: the default configuration and
// a CNT_W=2 instance that exercises mismatch counter saturation.
module tb_oj_judge_monitor;

  localparam int WIN_LEN = 8;
  localparam int SKIP    = 2;
  localparam int CNT_W   = 8;
  localparam int CYC_W   = 8;
  localparam int RUN_CYC = SKIP + WIN_LEN + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic ref_out = 1'b0;
  logic dut_out = 1'b0;

  logic             busy, done, pass, mismatch;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CYC_W-1:0] first_err_cyc;
  logic [CNT_W-1:0] cycle_cnt;

  logic             sat_busy, sat_done, sat_pass, sat_mismatch;
  logic [1:0]       sat_cnt;
  logic [CYC_W-1:0] sat_first;
  logic [1:0]       sat_cc;

`ifdef OJ_JUDGE_HIST_EN
  logic [7:0] hist_ref, hist_dut, sat_hist_ref, sat_hist_dut;
`endif

  oj_judge_monitor #(.WIN_LEN(WIN_LEN), .SKIP(SKIP), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ref_out(ref_out), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .mismatch_cnt(mismatch_cnt), .first_err_cyc(first_err_cyc), .cycle_cnt(cycle_cnt)
`ifdef OJ_JUDGE_HIST_EN
    , .hist_ref(hist_ref), .hist_dut(hist_dut)
`endif
  );

  oj_judge_monitor #(.WIN_LEN(WIN_LEN), .SKIP(SKIP), .CNT_W(2), .CYC_W(CYC_W)) dut_sat (
    .clk(clk), .rstn(rstn), .start(start), .ref_out(ref_out), .dut_out(dut_out),
    .busy(sat_busy), .done(sat_done), .pass(sat_pass), .mismatch(sat_mismatch),
    .mismatch_cnt(sat_cnt), .first_err_cyc(sat_first), .cycle_cnt(sat_cc)
`ifdef OJ_JUDGE_HIST_EN
    , .hist_ref(sat_hist_ref), .hist_dut(sat_hist_dut)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    bit done;
    bit mis;
    int cc;
  } cyc_exp_t;

  typedef struct {
    bit         pass;
    int         cnt;
    int         sat_cnt;
    int         first;
    logic [7:0] href;
    logic [7:0] hdut;
    int         done_cyc;
  } res_exp_t;

  cyc_exp_t cyc_q[$];
  res_exp_t res_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit model_done = 1'b0;
  int model_cc = 0;

  // Free-running cycle counter used to time the verdict.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_mismatch"}, mismatch, 0);
    checkOutput({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
    checkOutput({tag, "_cycle_cnt"}, cycle_cnt, 0);
    checkOutput({tag, "_first_err_cyc"}, first_err_cyc, 255);
    checkOutput({tag, "_sat_cnt"}, sat_cnt, 0);
`ifdef OJ_JUDGE_HIST_EN
    checkOutput({tag, "_hist_ref"}, hist_ref, 0);
    checkOutput({tag, "_hist_dut"}, hist_dut, 0);
`endif
  endtask

  // One bench cycle: drive inputs, queue the per-cycle expectation, advance.
  task automatic driveCycle(input bit st, input bit r, input bit d,
                            input bit eBusy, input bit eDone, input bit eMis, input int eCc);
    cyc_exp_t e;
    start   = st;
    ref_out = r;
    dut_out = d;
    e.busy = eBusy;
    e.done = eDone;
    e.mis  = eMis;
    e.cc   = eCc;
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      driveCycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, model_done, 1'b0, model_cc);
    end
  endtask

  // One judging run. Bit j of rv/dv/glitch is the value driven in cycle j,
  // cycle 0 being the start cycle. abort_at >= 0 pulses reset in that cycle.
  task automatic applyStimulus(input logic [31:0] rv, input logic [31:0] dv,
                               input logic [31:0] glitch, input int abort_at);
    res_exp_t   r;
    int         n, first, last, lo, preN;
    logic [7:0] hr, hd;
    n = 0;
    first = -1;
    preN = 0;
    for (int k = 0; k < WIN_LEN; k++) begin
      if (rv[SKIP+1+k] != dv[SKIP+1+k]) begin
        n++;
        if (first < 0) first = k;
        if (SKIP + 1 + k < abort_at) preN++;
      end
    end
    last = (first < 0) ? WIN_LEN - 1 : first;
    lo = (last >= 7) ? last - 7 : 0;
    hr = '0;
    hd = '0;
    for (int k = lo; k <= last; k++) begin
      hr = {hr[6:0], rv[SKIP+1+k]};
      hd = {hd[6:0], dv[SKIP+1+k]};
    end
    r.pass     = (n == 0);
    r.cnt      = (n > 255) ? 255 : n;
    r.sat_cnt  = (n > 3) ? 3 : n;
    r.first    = (first < 0) ? 255 : first;
    r.href     = hr;
    r.hdut     = hd;
    r.done_cyc = cyc + SKIP + WIN_LEN + 1;
    if (abort_at < 0) res_q.push_back(r);
    for (int j = 0; j < RUN_CYC; j++) begin
      if (j == abort_at) begin
        checkOutput("pre_abort_cnt", mismatch_cnt, preN);
        start   = 1'b0;
        ref_out = 1'b1;
        dut_out = 1'b0;
        #1 rstn = 1'b0;
        cyc_q.delete();
        #1;
        resetChecks("abort");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_done = 1'b0;
        model_cc = 0;
        return;
      end
      if (j == 0)
        driveCycle(1'b1, rv[j], dv[j], 1'b0, model_done, 1'b0, model_cc);
      else if (j <= SKIP)
        driveCycle(glitch[j], rv[j], dv[j], 1'b1, 1'b0, 1'b0, 0);
      else
        driveCycle(glitch[j], rv[j], dv[j], 1'b1, 1'b0, rv[j] ^ dv[j], j - SKIP - 1);
    end
    model_done = 1'b1;
    model_cc = WIN_LEN - 1;
  endtask

  function automatic logic [31:0] placeSamples(input logic [7:0] s);
    return 32'(s) << (SKIP + 1);
  endfunction

  // Monitor: checks per-cycle status and pops the verdict when done rises.
  initial begin : monitor
    cyc_exp_t e;
    res_exp_t r;
    bit prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (cyc_q.size() > 0) begin
          e = cyc_q.pop_front();
          checkOutput("busy", busy, e.busy);
          checkOutput("done", done, e.done);
          checkOutput("mismatch", mismatch, e.mis);
          checkOutput("cycle_cnt", cycle_cnt, e.cc);
          checkOutput("sat_done", sat_done, e.done);
          checkOutput("sat_mismatch", sat_mismatch, e.mis);
          checkOutput("sat_cycle_cnt", sat_cc, e.cc % 4);
        end
        if (done && !prevDone) begin
          if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
          end else begin
            r = res_q.pop_front();
            checkOutput("done_cycle", cyc, r.done_cyc);
            checkOutput("pass", pass, r.pass);
            checkOutput("mismatch_cnt", mismatch_cnt, r.cnt);
            checkOutput("first_err_cyc", first_err_cyc, r.first);
            checkOutput("sat_mismatch_cnt", sat_cnt, r.sat_cnt);
            checkOutput("sat_first_err_cyc", sat_first, r.first);
            checkOutput("sat_pass", sat_pass, r.pass);
`ifdef OJ_JUDGE_HIST_EN
            checkOutput("hist_ref", hist_ref, r.href);
            checkOutput("hist_dut", hist_dut, r.hdut);
            checkOutput("sat_hist_ref", sat_hist_ref, r.href);
`endif
          end
        end
        prevDone = done;
      end else begin
        prevDone = 1'b0;
      end
    end
  end

  // Stimulus: directed runs from the test plan, then randomized runs.
  initial begin : stimulus
    logic [31:0] tog, rv, dv, gl;
    int mode;
    tog = 32'hAAAA_AAAA;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetChecks("reset");
    rstn = 1'b1;

    applyStimulus(tog, tog, 32'h0, -1);
    idleCycles(2);
    applyStimulus(tog, tog ^ (32'h1 << (SKIP + 4)) ^ (32'h1 << (SKIP + 6)), 32'h0, -1);
    idleCycles(1);
    applyStimulus(tog, tog ^ 32'h0000_0007 ^ 32'hFFFF_F800, 32'h0, -1);
    applyStimulus(tog, ~tog, 32'h0000_054A, -1);
    idleCycles(3);
    rv = placeSamples(8'h6D);
    applyStimulus(rv, rv ^ placeSamples(8'h94), 32'h0, -1);
    idleCycles(4);

    for (int i = 0; i < 24; i++) begin
      rv = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: dv = rv;
        1: dv = rv ^ ($urandom & $urandom & $urandom);
        2: dv = rv ^ $urandom;
        default: dv = ~rv;
      endcase
      gl = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000_07FE) : 32'h0;
      applyStimulus(rv, dv, gl, -1);
      idleCycles($urandom_range(0, 3));
    end

    applyStimulus(tog, tog ^ (32'h1 << (SKIP + 2)), 32'h0, SKIP + 1 + 4);
    idleCycles(1);
    applyStimulus(tog, tog, 32'h0, -1);
    idleCycles(3);

    for (int i = 0; i < 20 && res_q.size() > 0; i++) @(posedge clk);
    if (res_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL verdict_timeout: %0d runs never reported done", res_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
